// File: rtl/edge_event_logger.sv
// edge_event_logger: time-stamps nonzero edge vectors into a show-ahead FIFO with overflow tracking
module edge_event_logger #(
    parameter int W      = 8,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W-1:0]               edge_in,
    input  logic                       log_en,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [W-1:0]               evt_edges,
    output logic [TS_W-1:0]            evt_ts,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_cnt,
    input  logic                       clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [TS_W-1:0]   r_ts;
    logic [W-1:0]      r_mem_e [DEPTH];
    logic [TS_W-1:0]   r_mem_ts [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [FW-1:0]     r_fill;
    logic              r_ovf;
    logic [DROP_W-1:0] r_drop;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_wr;
    logic w_drop;

    assign w_push = log_en && (edge_in != '0);
    assign w_pop  = (r_fill != '0) && evt_ready;
    assign w_full = r_fill == FW'(DEPTH);
    // a pop in the same edge frees the slot, so a full FIFO still accepts the push
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    // free-running timestamp, wraps silently
    always_ff @(posedge clk) begin
        if (rst) r_ts <= '0;
        else     r_ts <= r_ts + TS_W'(1);
    end

    // entry storage; stale contents are unreachable once fill is cleared
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_e[r_wptr]  <= edge_in;
            r_mem_ts[r_wptr] <= r_ts;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_fill <= (w_wr && !w_pop) ? r_fill + FW'(1) :
                      (!w_wr && w_pop) ? r_fill - FW'(1) : r_fill;
        end
    end

    // sticky overflow and saturating drop counter; a drop beats a coincident clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_drop) begin
            r_ovf  <= 1'b1;
            r_drop <= clr_ovf ? DROP_W'(1) : (&r_drop) ? r_drop : r_drop + DROP_W'(1);
        end else if (clr_ovf) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end
    end

    assign evt_valid = r_fill != '0;
    assign evt_edges = evt_valid ? r_mem_e[r_rptr]  : '0;
    assign evt_ts    = evt_valid ? r_mem_ts[r_rptr] : '0;
    assign fill      = r_fill;
    assign overflow  = r_ovf;
    assign drop_cnt  = r_drop;
endmodule

// File: tb/tb_edge_event_logger.sv
// tb_edge_event_logger: queue-model bench with directed vectors for edge_event_logger
module tb_edge_event_logger;
    localparam int W = 8, TS_W = 16, DEPTH = 8, DROP_W = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  edge_in = '0;
    logic          log_en = 1'b0;
    logic          evt_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          evt_valid;
    logic [W-1:0]  evt_edges;
    logic [TS_W-1:0] evt_ts;
    logic [3:0]    fill;
    logic          overflow;
    logic [DROP_W-1:0] drop_cnt;

    always #5 clk = ~clk;

    edge_event_logger #(.W(W), .TS_W(TS_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst(rst), .edge_in(edge_in), .log_en(log_en),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_edges(evt_edges),
        .evt_ts(evt_ts), .fill(fill), .overflow(overflow), .drop_cnt(drop_cnt),
        .clr_ovf(clr_ovf)
    );

    typedef struct packed {
        logic [15:0] ts;
        logic [7:0]  e;
    } ev_t;

    ev_t         mq[$];
    ev_t         mlog[$];
    logic [15:0] m_ts = '0;
    bit          m_ovf = 0;
    int          m_drop = 0;
    bit          chk_en = 0;
    int          max_fill = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          m_push, m_pop, m_dropev;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // reference model: FIFO as a queue, updated from the inputs seen at each rising edge
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ts   = '0;
            m_ovf  = 0;
            m_drop = 0;
            chk_en = 1;
        end else begin
            m_push   = log_en && edge_in != 0;
            m_pop    = evt_ready && mq.size() != 0;
            m_dropev = m_push && mq.size() == DEPTH && !m_pop;
            if (m_pop) mlog.push_back(mq.pop_front());
            if (m_push && !m_dropev) mq.push_back({m_ts, edge_in});
            if (m_dropev) begin
                m_ovf  = 1;
                m_drop = clr_ovf ? 1 : (m_drop == 255 ? 255 : m_drop + 1);
            end else if (clr_ovf) begin
                m_ovf  = 0;
                m_drop = 0;
            end
            m_ts = m_ts + 16'd1;
            if (mq.size() > max_fill) max_fill = mq.size();
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("evt_valid", evt_valid, mq.size() != 0);
            chk("fill", fill, mq.size());
            chk("evt_edges", evt_edges, mq.size() != 0 ? mq[0].e : 8'd0);
            chk("evt_ts", evt_ts, mq.size() != 0 ? mq[0].ts : 16'd0);
            chk("overflow", overflow, m_ovf);
            chk("drop_cnt", drop_cnt, m_drop);
        end
    end

    task automatic cyc(input logic [7:0] e, input logic r, input logic l, input logic c);
        edge_in = e; evt_ready = r; log_en = l; clr_ovf = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(8'h5A, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        // single event, held while not ready
        do_reset();
        repeat (3) cyc(8'h00, 0, 1, 0);
        cyc(8'h45, 0, 1, 0);
        chk("t1_valid", evt_valid, 1);
        chk("t1_edges", evt_edges, 8'h45);
        chk("t1_ts", evt_ts, 3);
        chk("t1_fill", fill, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(8'h00, 0, 1, 0);
            chk("t1_hold_edges", evt_edges, 8'h45);
            chk("t1_hold_ts", evt_ts, 3);
        end
        cyc(8'h00, 1, 1, 0);
        chk("t1_drained", evt_valid, 0);
        // zero edge vector creates no entry
        chk("t2_start_ts", m_ts, 10);
        max_fill = 0;
        mlog.delete();
        cyc(8'h62, 1, 1, 0);
        cyc(8'h00, 1, 1, 0);
        cyc(8'h62, 1, 1, 0);
        repeat (3) cyc(8'h00, 1, 1, 0);
        chk("t2_count", mlog.size(), 2);
        chk("t2_ev0_ts", mlog[0].ts, 10);
        chk("t2_ev0_e", mlog[0].e, 8'h62);
        chk("t2_ev1_ts", mlog[1].ts, 12);
        chk("t2_ev1_e", mlog[1].e, 8'h62);
        chk("t2_maxfill", max_fill, 1);
        // overflow with 10 pushes into 8 slots
        do_reset();
        for (int i = 0; i < 10; i++) cyc(8'(i + 1), 0, 1, 0);
        chk("t3_fill", fill, 8);
        chk("t3_ovf", overflow, 1);
        chk("t3_drop", drop_cnt, 2);
        // full: push and pop on the same edge
        mlog.delete();
        cyc(8'hAA, 1, 1, 0);
        chk("t4_fill", fill, 8);
        chk("t4_drop", drop_cnt, 2);
        repeat (10) cyc(8'h00, 1, 1, 0);
        chk("t4_count", mlog.size(), 9);
        for (int i = 0; i < 8; i++) begin
            chk("t3_order_ts", mlog[i].ts, i);
            chk("t3_order_e", mlog[i].e, i + 1);
        end
        chk("t4_last_ts", mlog[8].ts, 10);
        chk("t4_last_e", mlog[8].e, 8'hAA);
        // drop counter saturation and clear behaviour
        do_reset();
        repeat (8 + 255) cyc(8'h11, 0, 1, 0);
        chk("t5_drop255", drop_cnt, 255);
        cyc(8'h11, 0, 1, 0);
        chk("t5_sat", drop_cnt, 255);
        cyc(8'h00, 0, 1, 1);
        chk("t5_clr_ovf", overflow, 0);
        chk("t5_clr_drop", drop_cnt, 0);
        cyc(8'h11, 0, 1, 1);
        chk("t5_win_ovf", overflow, 1);
        chk("t5_win_drop", drop_cnt, 1);
        // reset mid-operation and log_en gating
        do_reset();
        repeat (5) cyc(8'h3C, 0, 1, 0);
        chk("t6_fill5", fill, 5);
        do_reset();
        chk("t6_valid", evt_valid, 0);
        chk("t6_fill", fill, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_edges", evt_edges, 0);
        repeat (3) cyc(8'hFF, 0, 0, 0);
        chk("t6_logen_fill", fill, 0);
        cyc(8'h81, 0, 1, 0);
        chk("t6_ts", evt_ts, 3);
        chk("t6_edges_new", evt_edges, 8'h81);
        cyc(8'h00, 1, 0, 0);
        chk("t6_empty", evt_valid, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/edge_event_logger.md
Name: edge_event_logger

Overview:
- Downstream consumer of the dual-edge detector's `anyedge[7:0]` vector.
- Each cycle with a nonzero edge vector is time-stamped against a free-running cycle counter. The edge vector plus timestamp are buffered in a small show-ahead FIFO.
- Events are presented to a downstream reader over a valid/ready interface.
- Overflow is detected, dropped events are counted, and a sticky overflow flag is raised so software or a monitor can tell that events were lost.

Parameters:
- W, 8, width of the edge vector (matches detector output width).
- TS_W, 16, timestamp counter width.
- DEPTH, 8, FIFO entries; must be a power of two and at least 2.
- DROP_W, 8, width of the dropped-event counter.

Ports:
- clk  in  1  rising-edge clock shared with the edge detector.
- rst  in  1  synchronous reset, active-high.
- edge_in  in  W  edge vector from the detector (`anyedge`); bit set = that input toggled.
- log_en  in  1  1 = capture events; 0 = ignore `edge_in` (timestamp still runs).
- evt_valid  out  1  head entry available.
- evt_ready  in  1  downstream accepts head entry.
- evt_edges  out  W  edge vector of head entry.
- evt_ts  out  TS_W  timestamp of head entry.
- fill  out  $clog2(DEPTH)+1  current number of stored entries.
- overflow  out  1  sticky; set when an event was dropped.
- drop_cnt  out  DROP_W  number of dropped events, saturating.
- clr_ovf  in  1  clears `overflow` and `drop_cnt`.

Behaviour:
- Reset (sync, `rst`=1 at a rising edge): all of the following are 0 from the next cycle.
  - `ts`, write pointer, read pointer, `fill`.
  - `evt_valid`, `overflow`, `drop_cnt`.
  - `evt_edges` and `evt_ts` read 0 while empty.
  - Any entries in the FIFO are discarded.
- Reset overrides every other input, including `clr_ovf` and `evt_ready`.
- Timestamp:
  - Internal `ts` increments by 1 every cycle that `rst`=0.
  - Wraps from 2^TS_W-1 to 0 with no flag.
  - The first cycle after reset deasserts samples `ts`=0.
- Push condition: `log_en`=1 and `edge_in` != 0, sampled at the rising edge.
  - Entry = {`ts` value at that edge, `edge_in`}.
  - `edge_in`=0 never creates an entry.
- Pop condition: `evt_valid`=1 and `evt_ready`=1 at a rising edge; the head advances.
- FIFO is show-ahead:
  - `evt_valid` = (`fill` != 0).
  - `evt_edges`/`evt_ts` are driven from the head entry, registered storage, no combinational path from `edge_in`.
- Latency: an event pushed at edge N into an empty FIFO gives `evt_valid`=1 with that entry visible after edge N, i.e. in cycle N+1. There is no bypass.
- `fill` update per edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Full (`fill`=DEPTH):
  - Push with no pop: entry dropped, FIFO unchanged.
  - Push with pop in the same edge: pop frees a slot, push accepted, `fill` stays DEPTH, no drop.
- Drop: `overflow` <= 1; `drop_cnt` <= `drop_cnt`+1, saturating at 2^DROP_W-1 (no wrap).
- `clr_ovf`=1: `overflow` <= 0 and `drop_cnt` <= 0. If a drop occurs in the same edge, the drop wins: `overflow`=1 and `drop_cnt`=1.
- Empty (`fill`=0):
  - `evt_ready` is ignored, no pointer movement.
  - A push in the same edge is accepted normally.
- Pointers wrap modulo DEPTH. `fill` distinguishes full from empty.
- Handshake rule: while `evt_valid`=1 and `evt_ready`=0, `evt_edges`/`evt_ts` hold stable.
- `log_en` falling: does not affect stored entries or the output side.
- Reset mid-operation: all stored entries are lost; nothing is output after reset until a new push.

Test Plan:
- Reset then `edge_in`=8'b0100_0101 at the edge where `ts`=3, `evt_ready`=0 -> next cycle `evt_valid`=1, `evt_edges`=8'h45, `evt_ts`=3, `fill`=1; values held for 5 cycles.
- Edges 8'h62, 8'h00, 8'h62 on three consecutive edges (`ts`=10,11,12), `evt_ready`=1 continuously -> exactly two events output: (8'h62, ts 10) then (8'h62, ts 12); `fill` never exceeds 1.
- `evt_ready`=0, nonzero `edge_in` for 10 consecutive edges, DEPTH=8 -> `fill`=8, `overflow`=1, `drop_cnt`=2; drain yields the first 8 timestamps in order.
- FIFO full, push and pop on the same edge -> `fill` stays 8, `drop_cnt` unchanged, newest entry appears 8th in drain order.
- `drop_cnt`=255 plus one more drop -> stays 255. Pulse `clr_ovf` with no drop -> `overflow`=0, `drop_cnt`=0. `clr_ovf` coincident with a drop -> `overflow`=1, `drop_cnt`=1.
- Assert `rst` for 1 cycle with `fill`=5 -> next cycle `evt_valid`=0, `fill`=0, `overflow`=0; `ts` restarts at 0. `log_en`=0 with nonzero `edge_in` -> no entries.
